// File: rtl/acc_cpu_ctrl.sv
// acc_cpu_ctrl: eight-phase control sequencer for the 8-bit accumulator CPU.
// Latency: controls decode combinationally from the current phase; one instruction every 8 clk.
// Backpressure: none; free-runs every clk until HLT, then holds at phase 4 until rst.
module acc_cpu_ctrl #(
    parameter int OPW    = 3,
    parameter int NPHASE = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           sel,
    output logic           rd,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           ld_pc,
    output logic           ld_ac,
    output logic           data_e,
    output logic           wr,
    output logic           halt,
    output logic [2:0]     phase
);

    localparam logic [OPW-1:0] OP_HLT = OPW'(0);
    localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_LDA = OPW'(5);
    localparam logic [OPW-1:0] OP_STO = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);

    localparam logic [2:0] LAST_PH = 3'(NPHASE - 1);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    state_t state;
    state_t state_n;
    logic   halted;
    logic   halted_n;
    logic   aluop;

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
    assign phase = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= state_n;
            halted <= halted_n;
        end
    end

    // HLT freezes the phase at OP_ADDR; the halted flag is sticky until rst.
    always_comb begin
        state_n  = state;
        halted_n = halted;
        if (!halted) begin
            if (state == OP_ADDR && opcode == OP_HLT)
                halted_n = 1'b1;
            else if (state == LAST_PH)
                state_n = INST_ADDR;
            else
                state_n = state_t'(state + 3'd1);
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        wr     = 1'b0;
        halt   = 1'b0;
        if (rst) begin
            // all controls quiet while reset is held, including the PC select
        end else if (halted) begin
            halt = 1'b1;
        end else begin
            case (state)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    inc_pc = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Scoreboarded bench for acc_cpu_ctrl: a driver pushes expected controls per cycle,
// a negedge monitor pops and compares against the DUT.
module tb_acc_cpu_ctrl;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef struct packed {
        logic [8:0] o;
        logic [2:0] ph;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
    logic [2:0] phase;
    logic [8:0] dut_o;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   mphase = 0;
    bit   mhalt = 1'b0;

    acc_cpu_ctrl #(.OPW(3), .NPHASE(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_ac(ld_ac), .data_e(data_e), .wr(wr), .halt(halt), .phase(phase)
    );

    assign dut_o = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: each control expressed as the set of phases/opcodes where it is high.
    function automatic logic [8:0] model_out(bit r, bit h, int ph, logic [2:0] op, bit z);
        bit alu;
        bit e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_de, e_wr, e_halt;
        if (r) return 9'd0;
        if (h) return 9'b0_0000_0001;
        alu    = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        e_sel  = (ph < 4);
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        e_ldir = (ph == 2) || (ph == 3);
        e_inc  = (ph == 4) || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP);
        e_ldpc = (ph >= 6) && (op == JMP);
        e_ldac = (ph == 7) && alu;
        e_de   = (ph >= 6) && (op == STO);
        e_wr   = (ph == 7) && (op == STO);
        e_halt = (ph == 4) && (op == HLT);
        return {e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_de, e_wr, e_halt};
    endfunction

    task automatic cycle(input bit r, input logic [2:0] op, input bit z);
        exp_t e;
        @(posedge clk);
        #1;
        rst    = r;
        opcode = op;
        zero   = z;
        if (r) begin
            mphase = 0;
            mhalt  = 1'b0;
        end
        e.o  = model_out(r, mhalt, mphase, op, z);
        e.ph = r ? 3'd0 : 3'(mphase);
        q.push_back(e);
        if (!r && !mhalt) begin
            if (mphase == 4 && op == HLT) mhalt = 1'b1;
            else mphase = (mphase + 1) % 8;
        end
    endtask

    task automatic instr(input logic [2:0] op, input bit z);
        for (int i = 0; i < 8; i++) cycle(1'b0, op, z);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("controls", 16'(dut_o), 16'(e.o));
                chk("phase", 16'(phase), 16'(e.ph));
                chk("wr_implies_data_e", 16'(wr & ~data_e), 16'd0);
                chk("ld_ac_wr_exclusive", 16'(ld_ac & wr), 16'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [2:0] rop;
        #2 rst = 1'b1;
        #1;
        chk("reset_controls", 16'(dut_o), 16'd0);
        chk("reset_phase", 16'(phase), 16'd0);
        cycle(1'b1, ADD, 1'b0);
        cycle(1'b1, ADD, 1'b0);

        instr(ADD, 1'b0);
        instr(STO, 1'b1);
        instr(SKZ, 1'b1);
        instr(SKZ, 1'b0);
        instr(JMP, 1'b1);
        instr(LDA, 1'b0);

        for (int i = 0; i < 64; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (mphase == 4 && rop == HLT) rop = XOR;
            cycle(1'b0, rop, 1'($urandom_range(0, 1)));
        end

        // async reset in the middle of a STO's ALU_OP phase
        for (int i = 0; i < 8 && mphase != 6; i++) cycle(1'b0, STO, 1'b0);
        cycle(1'b0, STO, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_data_e", 16'(data_e), 16'd0);
        chk("async_rst_wr", 16'(wr), 16'd0);
        chk("async_rst_phase", 16'(phase), 16'd0);
        mphase = 0;
        mhalt  = 1'b0;
        cycle(1'b1, STO, 1'b0);
        instr(STO, 1'b0);

        // halt is sticky against arbitrary opcodes until reset
        for (int i = 0; i < 8 && mphase != 4; i++) cycle(1'b0, ADD, 1'b0);
        cycle(1'b0, HLT, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("halt_rst_halt", 16'(halt), 16'd0);
        chk("halt_rst_phase", 16'(phase), 16'd0);
        mphase = 0;
        mhalt  = 1'b0;
        cycle(1'b1, ADD, 1'b0);
        instr(AND, 1'b1);

        @(negedge clk);
        #1;
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
